// File: rtl/logic_op_sequencer_if.sv
// Switch/button side and logic-unit side signals of the operand/opcode sequencer.
// The master side is the board plus logic unit; the slave side is the sequencer.
interface logic_op_sequencer_if #(
   parameter int WIDTH = 2,
   parameter int CNT_W = 4
);
   logic [WIDTH-1:0] din;
   logic             load;
   logic             clr;
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic [1:0]       op_out;
   logic [WIDTH-1:0] f_in;
   logic [WIDTH-1:0] result;
   logic             result_valid;
   logic [2:0]       state_out;
   logic [CNT_W-1:0] op_count;

   modport master (
      output din, load, clr, f_in,
      input  a_out, b_out, op_out, result, result_valid, state_out, op_count
   );

   modport slave (
      input  din, load, clr, f_in,
      output a_out, b_out, op_out, result, result_valid, state_out, op_count
   );
endinterface

// File: rtl/logic_op_sequencer.sv
// Loads A, B and opcode from a shared switch bus on successive button presses,
// holds them on the logic unit for one execute cycle, then registers its result.
module logic_op_sequencer #(
   parameter int WIDTH = 2,
   parameter int CNT_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   logic_op_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_DONE = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       sync_q;
   logic             ld_pulse;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Button is asynchronous: two flops resolve metastability, the third gives
   // the previous level so a held button produces a single rising-edge pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], bus.load};
      end
   end

   assign ld_pulse = sync_q[1] & ~sync_q[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_A;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      valid_d  = valid_q;
      count_d  = count_q;

      // Clear wins over any press landing on the same edge.
      if (bus.clr) begin
         state_d  = S_A;
         a_d      = '0;
         b_d      = '0;
         op_d     = '0;
         result_d = '0;
         valid_d  = 1'b0;
         count_d  = '0;
      end else begin
         case (state_q)
            S_A: begin
               if (ld_pulse) begin
                  a_d     = bus.din;
                  valid_d = 1'b0;
                  state_d = S_B;
               end
            end
            S_B: begin
               if (ld_pulse) begin
                  b_d     = bus.din;
                  state_d = S_OP;
               end
            end
            S_OP: begin
               if (ld_pulse) begin
                  op_d    = bus.din[1:0];
                  state_d = S_EXEC;
               end
            end
            S_EXEC: begin
               // Operands have been stable a full cycle, so f_in has settled.
               result_d = bus.f_in;
               valid_d  = 1'b1;
               count_d  = count_q + CNT_W'(1);
               state_d  = S_DONE;
            end
            S_DONE: begin
               if (ld_pulse) begin
                  state_d = S_A;
               end
            end
            default: begin
               state_d = S_A;
            end
         endcase
      end
   end

   assign bus.a_out        = a_q;
   assign bus.b_out        = b_q;
   assign bus.op_out       = op_q;
   assign bus.result       = result_q;
   assign bus.result_valid = valid_q;
   assign bus.state_out    = state_q;
   assign bus.op_count     = count_q;

endmodule

// File: doc/logic_op_sequencer.md
Name: logic_op_sequencer

Overview:
- Upstream operand/opcode sequencer for the 2-bit bitwise logic unit.
- Loads operand A, operand B and a 2-bit opcode, one per press of a single button, from a shared switch bus.
- Drives the logic unit's a/b/i inputs steadily, then registers the unit's f result and counts executed operations.
- Sits between board switches/button and the combinational logic unit.

Parameters:
- WIDTH, 2, operand/result width in bits (one logic-unit bit slice per bit).
- CNT_W, 4, width of the executed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  switch bus; holds A, B or the opcode value depending on state.
- load  input  1  raw button level, asynchronous to clk.
- clr  input  1  synchronous clear, active high.
- a_out  output  WIDTH  operand A to logic unit (a1..a0).
- b_out  output  WIDTH  operand B to logic unit (b1..b0).
- op_out  output  2  opcode to logic unit; op_out[0]=i0, op_out[1]=i1.
- f_in  input  WIDTH  result from logic unit (f1..f0).
- result  output  WIDTH  registered result.
- result_valid  output  1  result holds the current operands' output.
- state_out  output  3  current FSM state encoding.
- op_count  output  CNT_W  executed operations, wraps.

Behaviour:
- Reset (rst_n low, async): all outputs 0, state S_A, synchronizer flops 0.
- Load synchronizer:
  - 3-flop chain s1→s2→s3 on load.
  - ld_pulse = s2 & ~s3, lasting one cycle.
  - Capture occurs on the 3rd rising edge after load is first sampled high.
  - A button held high gives exactly one pulse; a new pulse requires load low for at least 1 sampled cycle.
- FSM states (state_out): S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_DONE=4.
  - S_A: on ld_pulse, a_out<=din, result_valid<=0, go S_B.
  - S_B: on ld_pulse, b_out<=din, go S_OP.
  - S_OP: on ld_pulse, op_out<=din[1:0] (upper din bits ignored when WIDTH>2), go S_EXEC.
  - S_EXEC: exactly one cycle, ignores ld_pulse.
    - a_out/b_out/op_out are stable for this whole cycle.
    - At the ending edge: result<=f_in, result_valid<=1, op_count<=op_count+1 (mod 2^CNT_W), go S_DONE.
  - S_DONE: result and all operands held; on ld_pulse go S_A with no capture of din.
  - Codes 5-7 are illegal: next state S_A, no register changes.
- clr (sampled at rising edge):
  - Overrides ld_pulse.
  - Forces S_A and zeroes a_out, b_out, op_out, result, result_valid and op_count.
  - Synchronizer flops are unaffected.
- Result latency: f_in is captured 1 cycle after the opcode capture edge. The logic unit is combinational, and operands are already stable one full cycle before sampling.
- Operands never change outside their load states; the logic unit's inputs are glitch-free apart from capture edges.
- Reset mid-operation (any state): immediate return to reset values; a press in flight is lost.
- op_count wrap: 2^CNT_W-1 → 0 on the next EXEC.
- Opcode semantics for the bench model, per bit {i1,i0}:
  - 00 = a AND b
  - 10 = a OR b
  - 01 = a XNOR b
  - 11 = NOT a

Test Plan:
- Reset then three presses with din=2'b11, 2'b01, 2'b00 → a_out=11, b_out=01, op_out=00; EXEC one cycle later; result=01, result_valid=1, op_count=1, state_out=4.
- Full sweep: A=10, B=11 through all four opcodes (00,10,01,11), each sequence S_A→S_DONE → results 10, 11, 10, 01 respectively; op_count=4.
- Hold load high for 50 cycles in S_A → single capture only, state_out=1; release 1 cycle, press again → state_out=2.
- Assert clr in S_OP simultaneously with ld_pulse → state_out=0, all registers 0, op_out not updated.
- Drop rst_n asynchronously mid-cycle in S_EXEC → outputs 0 before the next clock edge; result_valid=0.
- Run 16 complete operations with CNT_W=4 → op_count wraps to 0; the press in S_DONE returns to S_A and clears result_valid on the next A capture.
